sub_serial: RTL and testbench

//   Bit-serial subtractor; inverse companion of the bit-serial adder in the same datapath library.

---
 rtl/sub_serial.sv | 97 +++++++++
 tb/tb_sub_serial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial subtractor: captures a and b, shifts out a - b LSB-first one bit per
// cycle, then holds the difference and final borrow until released.
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             borrow_out,
    output logic [1:0]       state_o
);

    // Handshake: en is a level request. A capture happens on the rising edge where
    // en=1 in IDLE; en=1 in DONE only releases back to IDLE (no capture that edge).
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SUB  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               borrow_q, borrow_d;
    logic               diff_bit;

    assign diff_bit = a_q[0] ^ b_q[0] ^ borrow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    a_d      = a;
                    b_d      = b;
                    out_d    = '0;
                    count_d  = '0;
                    borrow_d = 1'b0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                // Each new bit enters at the MSB so the first (LSB) bit ends at out[0].
                out_d    = {diff_bit, out_q[WIDTH-1:1]};
                borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out        = out_q;
    assign done       = (state_q == DONE);
    assign borrow_out = (state_q == DONE) & borrow_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial at WIDTH=8 and WIDTH=16: directed scenarios plus random
// operations checked against a scoreboard of {borrow, difference}.
module tb_sub_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        en8, done8, bo8;
    logic [7:0]  a8, b8, out8;
    logic [1:0]  st8;
    logic        en16, done16, bo16;
    logic [15:0] a16, b16, out16;
    logic [1:0]  st16;

    int errors = 0;
    int checks = 0;

    logic [8:0]  exp_q[$];
    logic [16:0] exp16_q[$];

    always #5 clk = ~clk;

    sub_serial #(.WIDTH(8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .a(a8), .b(b8),
        .out(out8), .done(done8), .borrow_out(bo8), .state_o(st8)
    );

    sub_serial #(.WIDTH(16), .CNT_W(4)) dut16 (
        .clk(clk), .rst(rst), .en(en16), .a(a16), .b(b16),
        .out(out16), .done(done16), .borrow_out(bo16), .state_o(st16)
    );

    // ---------------- driver tasks (called and returning at a negedge) ----------------
    task automatic push8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        d = a - b;
        exp_q.push_back({(a < b), d});
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        a8 = a; b8 = b; en8 = 1'b1;
        push8(a, b);
        @(posedge clk); @(negedge clk);
        en8 = 1'b0;
    endtask

    task automatic wait_done8(output int k);
        k = 0;
        while (done8 !== 1'b1 && k < 40) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
    endtask

    task automatic release8();
        en8 = 1'b1;
        @(posedge clk); @(negedge clk);
        en8 = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_check8(input string name, input int k, input int exp_k);
        logic [8:0] e;
        checks++;
        if (k !== exp_k) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, k, exp_k);
        end
        if (exp_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (out8 !== e[7:0]) begin
            errors++;
            $display("FAIL %s out: got %0d expected %0d", name, out8, e[7:0]);
        end
        checks++;
        if (bo8 !== e[8]) begin
            errors++;
            $display("FAIL %s borrow_out: got %b expected %b", name, bo8, e[8]);
        end
    endtask

    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b);
        int k;
        start8(a, b);
        wait_done8(k);
        sb_check8(name, k, 8);
        release8();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if (out8 !== 8'd0 || done8 !== 1'b0 || bo8 !== 1'b0 || st8 !== 2'b00) begin
            errors++;
            $display("FAIL reset8: got out=%0d done=%b borrow=%b state=%0d expected 0/0/0/0",
                     out8, done8, bo8, st8);
        end
        checks++;
        if (out16 !== 16'd0 || done16 !== 1'b0 || bo16 !== 1'b0 || st16 !== 2'b00) begin
            errors++;
            $display("FAIL reset16: got out=%0d done=%b borrow=%b state=%0d expected 0/0/0/0",
                     out16, done16, bo16, st16);
        end
    endtask

    task automatic test_basic();
        int k;
        start8(8'd200, 8'd55);
        wait_done8(k);
        sb_check8("t1_200_55", k, 8);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (out8 !== 8'd145 || done8 !== 1'b1) begin
                errors++;
                $display("FAIL t1_hold: got out=%0d done=%b expected 145/1", out8, done8);
            end
        end
        release8();
        checks++;
        if (done8 !== 1'b0 || st8 !== 2'b00 || out8 !== 8'd145) begin
            errors++;
            $display("FAIL t1_release: got done=%b state=%0d out=%0d expected 0/0/145",
                     done8, st8, out8);
        end
    endtask

    task automatic test_boundaries();
        run8("t2_5_10", 8'd5, 8'd10);
        run8("t2_0_0", 8'd0, 8'd0);
        run8("t3_255_255", 8'd255, 8'd255);
        run8("t3_0_1", 8'd0, 8'd1);
        run8("t3_80_0", 8'h80, 8'h00);
    endtask

    task automatic test_ignore_inputs();
        int k;
        start8(8'd100, 8'd30);
        k = 0;
        while (done8 !== 1'b1 && k < 40) begin
            en8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(posedge clk); @(negedge clk);
            k++;
        end
        en8 = 1'b0;
        sb_check8("t4_ignore", k, 8);
        release8();
    endtask

    task automatic test_async_reset();
        a8 = 8'd9; b8 = 8'd3; en8 = 1'b1;
        @(posedge clk); @(negedge clk);
        en8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out8 !== 8'd0 || done8 !== 1'b0 || st8 !== 2'b00) begin
            errors++;
            $display("FAIL t5_abort: got out=%0d done=%b state=%0d expected 0/0/0",
                     out8, done8, st8);
        end
        @(negedge clk);
        rst = 1'b0;
        run8("t5_7_2", 8'd7, 8'd2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[3] = '{8'd10, 8'd4, 8'd77};
        logic [7:0] bv[3] = '{8'd4, 8'd10, 8'd77};
        int k;
        a8 = av[0]; b8 = bv[0]; en8 = 1'b1;
        push8(av[0], bv[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            k = 1;
            while (done8 !== 1'b1 && k < 40) begin
                @(posedge clk); @(negedge clk);
                k++;
            end
            sb_check8("t6_b2b", k, (i == 0) ? 9 : 10);
            if (i < 2) begin
                a8 = av[i+1]; b8 = bv[i+1];
                push8(av[i+1], bv[i+1]);
            end
        end
        en8 = 1'b0;
        release8();
    endtask

    task automatic test_random8();
        for (int i = 0; i < 1000; i++) begin
            run8("rand8", 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, d;
        logic [16:0] e;
        int k;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = (i % 8 == 0) ? a : 16'($urandom);
            d = a - b;
            a16 = a; b16 = b; en16 = 1'b1;
            exp16_q.push_back({(a < b), d});
            @(posedge clk); @(negedge clk);
            en16 = 1'b0;
            k = 0;
            while (done16 !== 1'b1 && k < 60) begin
                @(posedge clk); @(negedge clk);
                k++;
            end
            checks++;
            if (k !== 16) begin
                errors++;
                $display("FAIL rand16 latency: got %0d cycles expected 16", k);
            end
            e = exp16_q.pop_front();
            checks++;
            if (out16 !== e[15:0] || bo16 !== e[16]) begin
                errors++;
                $display("FAIL rand16 result: got out=%0d borrow=%b expected %0d/%b (a=%0d b=%0d)",
                         out16, bo16, e[15:0], e[16], a, b);
            end
            en16 = 1'b1;
            @(posedge clk); @(negedge clk);
            en16 = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        en8 = 1'b0; a8 = '0; b8 = '0;
        en16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_inputs();
        test_async_reset();
        test_back_to_back();
        test_random8();
        test_random16();
        checks++;
        if (exp_q.size() != 0 || exp16_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0",
                     exp_q.size(), exp16_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
